// File: rtl/riscv_pkg.sv
// Shared constants for the R-type execution sequencer:
// opcode, ALU control codes and FSM state encodings.
package riscv_pkg;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

endpackage

// File: rtl/r_type_exec_sequencer_if.sv
// Instruction-memory fetch port: req held until ack,
// data valid in the ack cycle.
interface r_type_exec_sequencer_if #(
  parameter int PC_W = 32
) ();

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/r_type_decode.sv
// Combinational R-type decoder: funct7/funct3/opcode to
// {funct7[5],funct3} ALU code plus a legality flag.
module r_type_decode
  import riscv_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = {funct7[5], funct3};
    legal    = 1'b0;
    if (opcode == OPC_R_TYPE) begin
      unique case (1'b1)
        (funct7 == F7_BASE): legal = 1'b1;
        (funct7 == F7_ALT):
          legal = (funct3 == 3'b000) ||
                  (funct3 == 3'b101);
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/r_type_exec_sequencer.sv
// Multi-cycle R-type sequencer: FETCH/DECODE/EXEC/WB
// over a req/ack imem port, halting on illegal words.
module r_type_exec_sequencer
  import riscv_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  r_type_exec_sequencer_if.master imem,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [3:0]      alu_ctrl,
  output logic            reg_write,
  output logic            retired,
  output logic            illegal,
  output logic            busy,
  output logic [PC_W-1:0] pc
);

  state_t      state;
  logic [31:0] ir;
  logic        req;
  logic [3:0]  dec_alu;
  logic        dec_legal;

  r_type_decode u_dec (
    .funct7   (ir[31:25]),
    .funct3   (ir[14:12]),
    .opcode   (ir[6:0]),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  assign rs1_addr       = ir[19:15];
  assign rs2_addr       = ir[24:20];
  assign rd_addr        = ir[11:7];
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      alu_ctrl  <= '0;
      req       <= 1'b0;
      reg_write <= 1'b0;
      retired   <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      retired   <= 1'b0;
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            illegal <= 1'b0;
            busy    <= 1'b1;
            req     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem.imem_ack) begin
            ir    <= imem.imem_rdata;
            req   <= 1'b0;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            alu_ctrl <= dec_alu;
            state    <= EXEC;
          end else begin
            illegal <= 1'b1;
            busy    <= 1'b0;
            state   <= HALT;
          end
        end
        EXEC: begin
          // strobes are registered so they line up with WB
          reg_write <= (rd_addr != 5'd0);
          retired   <= 1'b1;
          state     <= WB;
        end
        WB: begin
          pc <= pc + PC_W'(4);
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            req   <= 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_type_exec_sequencer.sv
// Directed bench: vector table streamed through the
// sequencer plus wait-state and reset corner sequences.
module tb_r_type_exec_sequencer;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] word;
    logic        legal;
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_ctrl;
  logic        reg_write;
  logic        retired;
  logic        illegal;
  logic        busy;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  r_type_exec_sequencer_if #(.PC_W(32)) imem ();

  r_type_exec_sequencer #(
    .PC_W     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .imem      (imem),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .alu_ctrl  (alu_ctrl),
    .reg_write (reg_write),
    .retired   (retired),
    .illegal   (illegal),
    .busy      (busy),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] w,
                          input int wait_n);
    int n;
    logic [31:0] a0;
    n = 0;
    while (!imem.imem_req && n < 10) begin
      step();
      n++;
    end
    chk("req_seen", 32'(imem.imem_req), 32'd1);
    a0 = imem.imem_addr;
    for (int i = 0; i < wait_n; i++) begin
      imem.imem_ack = 1'b0;
      step();
      chk("req_held", 32'(imem.imem_req), 32'd1);
      chk("addr_hold", imem.imem_addr, a0);
      chk("wait_no_ret", 32'(retired), 32'd0);
    end
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = w;
    step();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
  endtask

  vec_t        tbl[9];
  logic [31:0] exp_pc;
  logic [3:0]  last_alu;

  initial begin
    tbl[0] = '{32'h002081B3, 1'b1, ALU_ADD,  5'd1, 5'd2, 5'd3, 1'b1};
    tbl[1] = '{32'h40208233, 1'b1, ALU_SUB,  5'd1, 5'd2, 5'd4, 1'b1};
    tbl[2] = '{32'h4020D2B3, 1'b1, ALU_SRA,  5'd1, 5'd2, 5'd5, 1'b1};
    tbl[3] = '{32'h0020F2B3, 1'b1, ALU_AND,  5'd1, 5'd2, 5'd5, 1'b1};
    tbl[4] = '{32'h00208033, 1'b1, ALU_ADD,  5'd1, 5'd2, 5'd0, 1'b0};
    tbl[5] = '{32'h00208013, 1'b0, 4'd0,     5'd1, 5'd2, 5'd0, 1'b0};
    tbl[6] = '{32'h0020E333, 1'b1, ALU_OR,   5'd1, 5'd2, 5'd6, 1'b1};
    tbl[7] = '{32'h602081B3, 1'b0, 4'd0,     5'd1, 5'd2, 5'd3, 1'b0};
    tbl[8] = '{32'h0020B1B3, 1'b1, ALU_SLTU, 5'd1, 5'd2, 5'd3, 1'b1};

    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;

    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_alu", 32'(alu_ctrl), 32'd0);
    chk("rst_wr", 32'(reg_write), 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_rd", 32'(rd_addr), 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_req", 32'(imem.imem_req), 32'd1);
    exp_pc   = 32'd0;
    last_alu = 4'd0;

    for (int i = 0; i < 9; i++) begin
      if (i == 2) start = 1'b1;
      chk("fetch_addr", imem.imem_addr, exp_pc);
      do_fetch(tbl[i].word, 0);
      chk("dec_rs1", 32'(rs1_addr), 32'(tbl[i].rs1));
      chk("dec_rs2", 32'(rs2_addr), 32'(tbl[i].rs2));
      chk("dec_rd", 32'(rd_addr), 32'(tbl[i].rd));
      chk("dec_req", 32'(imem.imem_req), 32'd0);
      step();
      if (tbl[i].legal) begin
        chk("ex_alu", 32'(alu_ctrl), 32'(tbl[i].alu));
        chk("ex_wr", 32'(reg_write), 32'd0);
        step();
        chk("wb_wr", 32'(reg_write), 32'(tbl[i].wr));
        chk("wb_ret", 32'(retired), 32'd1);
        chk("wb_pc", pc, exp_pc);
        chk("wb_rd", 32'(rd_addr), 32'(tbl[i].rd));
        last_alu = tbl[i].alu;
        if (i == 8) begin
          start = 1'b1;
          stop  = 1'b1;
        end else begin
          start = 1'b0;
        end
        step();
        start  = 1'b0;
        stop   = 1'b0;
        exp_pc = exp_pc + 32'd4;
        chk("next_pc", pc, exp_pc);
        chk("next_ret", 32'(retired), 32'd0);
        if (i == 8) begin
          chk("stop_busy", 32'(busy), 32'd0);
          chk("stop_req", 32'(imem.imem_req), 32'd0);
        end else begin
          chk("next_req", 32'(imem.imem_req), 32'd1);
        end
      end else begin
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_wr", 32'(reg_write), 32'd0);
        chk("ill_ret", 32'(retired), 32'd0);
        chk("ill_alu", 32'(alu_ctrl), 32'(last_alu));
        step();
        chk("halt_stay", 32'(imem.imem_req), 32'd0);
        chk("halt_ret", 32'(retired), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        exp_pc = 32'd0;
        chk("clr_ill", 32'(illegal), 32'd0);
        chk("clr_pc", pc, 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
      end
    end

    // ack arrives after three wait cycles; stray ack in EXEC
    step();
    chk("idle_hold", 32'(busy), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    do_fetch(32'h002081B3, 3);
    chk("wait_rd", 32'(rd_addr), 32'd3);
    step();
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h40208233;
    step();
    imem.imem_ack = 1'b0;
    chk("stray_rd", 32'(rd_addr), 32'd3);
    chk("stray_alu", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("stray_wr", 32'(reg_write), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("wait_pc", pc, 32'd4);
    chk("wait_busy", 32'(busy), 32'd0);

    // reset during a fetch wait
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("fw_req", 32'(imem.imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("fw_rst_req", 32'(imem.imem_req), 32'd0);
    chk("fw_rst_busy", 32'(busy), 32'd0);
    chk("fw_rst_rd", 32'(rd_addr), 32'd0);
    step();
    #3 rst_n = 1'b1;
    step();

    // reset during WB of the second instruction
    start = 1'b1;
    step();
    start = 1'b0;
    do_fetch(32'h002081B3, 0);
    step();
    step();
    stop = 1'b0;
    step();
    do_fetch(32'h40208233, 0);
    step();
    step();
    chk("wb2_wr", 32'(reg_write), 32'd1);
    chk("wb2_pc", pc, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("wb_rst_wr", 32'(reg_write), 32'd0);
    chk("wb_rst_ret", 32'(retired), 32'd0);
    chk("wb_rst_pc", pc, 32'd0);
    chk("wb_rst_alu", 32'(alu_ctrl), 32'd0);
    chk("wb_rst_busy", 32'(busy), 32'd0);
    chk("wb_rst_rd", 32'(rd_addr), 32'd0);
    step();
    chk("wb_rst_hold", 32'(reg_write), 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_pc", pc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
